// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//   Fetch stage for the single-cycle controller/datapath. Owns the PC and
//   issues one instruction-memory read at a time. The returned word is held
//   on inst/inst_valid until the execute side acknowledges it with inst_ack,
//   and then the PC advances to the next_pc selected by pc_sel.
//
//   Handshake rules (all signals sampled on the rising edge of clk):
//     - A read request is accepted when imem_req and imem_ready are both 1 in
//       the same cycle. imem_req drops the cycle after acceptance, so at most
//       one read is ever outstanding.
//     - Read data is consumed in the cycle where imem_rvalid is 1 while the
//       fetch unit is waiting. imem_rvalid at any other time is ignored.
//     - The held instruction is retired in the cycle where inst_ack is 1
//       while inst_valid is 1. inst_ack at any other time is ignored.
//
//   Optional feature macro: INST_FETCH_ALIGN_CHK_EN
//     When defined, a misaligned next_pc or the reserved pc_sel value 11
//     sends the unit into a sticky FAULT state and raises fetch_fault.
//     When undefined, fetch_fault is tied low and pc_sel 11 is sequential.
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
   parameter int               INST_BIT_WIDTH = 32,
   parameter int               DBITS          = 32,
   parameter logic [DBITS-1:0] START_PC       = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   // instruction memory read port
   output logic                      imem_req,
   output logic [DBITS-1:0]          imem_addr,
   input  logic                      imem_ready,
   input  logic                      imem_rvalid,
   input  logic [INST_BIT_WIDTH-1:0] imem_rdata,
   // execute side
   output logic [INST_BIT_WIDTH-1:0] inst,
   output logic                      inst_valid,
   output logic [DBITS-1:0]          pc,
   output logic [DBITS-1:0]          pc_plus4,
   input  logic                      inst_ack,
   input  logic [1:0]                pc_sel,
   input  logic [15:0]               imm,
   input  logic [DBITS-1:0]          rs1_val,
   output logic                      fetch_fault
);

   // Fetch sequencing states. FAULT only exists with the alignment check.
   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2
`ifdef INST_FETCH_ALIGN_CHK_EN
      ,
      ST_FAULT = 2'd3
`endif
   } fetch_state_e;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   fetch_state_e              state_q, state_d;
   logic [DBITS-1:0]          pc_q, pc_d;
   logic [INST_BIT_WIDTH-1:0] inst_q, inst_d;
   logic                      inst_valid_q, inst_valid_d;
   logic                      req_c;

   logic [DBITS-1:0]          pc_plus4_c;
   logic [DBITS-1:0]          imm_sext;
   logic [DBITS-1:0]          imm_off;
   logic [DBITS-1:0]          next_pc;

`ifdef INST_FETCH_ALIGN_CHK_EN
   logic                      fault_q, fault_d;
   logic                      bad_target;
`endif

   // Next-PC arithmetic: the immediate is a signed word offset, so it is
   // sign-extended and scaled by 4. All sums wrap modulo 2^DBITS.
   always_comb begin
      pc_plus4_c = pc_q + DBITS'(4);
      imm_sext   = {{(DBITS-16){imm[15]}}, imm};
      imm_off    = imm_sext << 2;
      next_pc    = pc_plus4_c;
      case (pc_sel)
         PC_SEQ:    next_pc = pc_plus4_c;
         PC_BRANCH: next_pc = pc_plus4_c + imm_off;
         PC_JUMP:   next_pc = rs1_val + imm_off;
         default:   next_pc = pc_plus4_c;   // reserved encoding runs sequentially
      endcase
   end

`ifdef INST_FETCH_ALIGN_CHK_EN
   // A target is rejected when it is not word aligned or uses the reserved select.
   always_comb begin
      bad_target = (next_pc[1:0] != 2'b00) || (pc_sel == 2'b11);
   end
`endif

   // Fetch FSM: next state, register updates and the request strobe.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      req_c        = 1'b0;
`ifdef INST_FETCH_ALIGN_CHK_EN
      fault_d      = fault_q;
`endif
      case (state_q)
         ST_REQ: begin
            req_c = 1'b1;
            if (imem_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               inst_d       = imem_rdata;
               inst_valid_d = 1'b1;
               state_d      = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (inst_ack) begin
               inst_valid_d = 1'b0;
`ifdef INST_FETCH_ALIGN_CHK_EN
               if (bad_target) begin
                  // PC is left pointing at the instruction that produced the fault.
                  fault_d = 1'b1;
                  state_d = ST_FAULT;
               end else begin
                  pc_d    = next_pc;
                  state_d = ST_REQ;
               end
`else
               pc_d    = next_pc;
               state_d = ST_REQ;
`endif
            end
         end
`ifdef INST_FETCH_ALIGN_CHK_EN
         ST_FAULT: begin
            // Sticky until reset: no requests, nothing captured.
            state_d = ST_FAULT;
         end
`endif
         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

   // State registers with synchronous, active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_REQ;
         pc_q         <= START_PC;
         inst_q       <= '0;
         inst_valid_q <= 1'b0;
`ifdef INST_FETCH_ALIGN_CHK_EN
         fault_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
`ifdef INST_FETCH_ALIGN_CHK_EN
         fault_q      <= fault_d;
`endif
      end
   end

   // The request is masked during the reset cycle so memory never sees a
   // request issued from a pre-reset state.
   assign imem_req   = req_c & ~reset;
   assign imem_addr  = pc_q;
   assign inst       = inst_q;
   assign inst_valid = inst_valid_q;
   assign pc         = pc_q;
   assign pc_plus4   = pc_plus4_c;
`ifdef INST_FETCH_ALIGN_CHK_EN
   assign fetch_fault = fault_q;
`else
   assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit
//   Drives inst_fetch_unit with a behavioural instruction memory and execute
//   side. Expected PCs come from a reference model that applies the next-PC
//   rules with plain integer arithmetic; fetched words are kept in an
//   expected queue and compared when they appear on inst.
// ---------------------------------------------------------------------------
module tb_inst_fetch_unit;

  localparam int          IW       = 32;
  localparam int          DW       = 32;
  localparam logic [31:0] START_PC = 32'h0;

  logic          clk;
  logic          reset;
  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic          imem_ready;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] inst;
  logic          inst_valid;
  logic [DW-1:0] pc;
  logic [DW-1:0] pc_plus4;
  logic          inst_ack;
  logic [1:0]    pc_sel;
  logic [15:0]   imm;
  logic [DW-1:0] rs1_val;
  logic          fetch_fault;

  int n_checks;
  int n_errors;

  logic [31:0] exp_pc;
  logic [IW-1:0] exp_q[$];

  inst_fetch_unit #(
    .INST_BIT_WIDTH(IW),
    .DBITS(DW),
    .START_PC(START_PC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst(inst),
    .inst_valid(inst_valid),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .inst_ack(inst_ack),
    .pc_sel(pc_sel),
    .imm(imm),
    .rs1_val(rs1_val),
    .fetch_fault(fetch_fault)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single comparison point
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference next-PC rule, computed with signed integer arithmetic
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] sel,
                                             input logic [15:0] im, input logic [31:0] rs1);
    int          off;
    logic [31:0] r;
    off = int'($signed(im)) * 4;
    case (sel)
      2'd1:    r = cur + 32'd4 + 32'(off);
      2'd2:    r = rs1 + 32'(off);
      default: r = cur + 32'd4;
    endcase
    return r;
  endfunction

  // one full fetch: request held rdly cycles, data vdly cycles late,
  // instruction held hdly cycles before the ack carrying sel/im/rs1
  task automatic fetch_one(input int rdly, input int vdly, input int hdly, input logic [IW-1:0] data,
                           input logic [1:0] sel, input logic [15:0] im, input logic [31:0] rs1);
    logic [IW-1:0] want;
    // request phase, memory not ready; stray rvalid must be ignored
    for (int i = 0; i < rdly; i++) begin
      check_val("req_held", {31'd0, imem_req}, 32'd1);
      check_val("addr_held", imem_addr, exp_pc);
      imem_ready  = 1'b0;
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      step();
    end
    imem_rvalid = 1'b0;
    check_val("req", {31'd0, imem_req}, 32'd1);
    check_val("addr", imem_addr, exp_pc);
    imem_ready = 1'b1;
    exp_q.push_back(data);
    step();
    imem_ready = 1'b0;
    // waiting for data; a stray ack must be ignored
    for (int i = 0; i < vdly; i++) begin
      check_val("wait_no_req", {31'd0, imem_req}, 32'd0);
      check_val("wait_not_valid", {31'd0, inst_valid}, 32'd0);
      inst_ack = 1'($urandom_range(0, 1));
      pc_sel   = 2'($urandom_range(0, 3));
      step();
    end
    inst_ack = 1'b0;
    check_val("no_req_after_accept", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
    want = exp_q.pop_front();
    // hold phase; stray rvalid with different data must not overwrite inst
    for (int i = 0; i < hdly; i++) begin
      check_val("hold_valid", {31'd0, inst_valid}, 32'd1);
      check_val("hold_inst", inst, want);
      check_val("hold_no_req", {31'd0, imem_req}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = ~data;
      step();
    end
    imem_rvalid = 1'b0;
    check_val("inst_valid", {31'd0, inst_valid}, 32'd1);
    check_val("inst", inst, want);
    check_val("pc", pc, exp_pc);
    check_val("pc_plus4", pc_plus4, exp_pc + 32'd4);
    check_val("no_fault", {31'd0, fetch_fault}, 32'd0);
    inst_ack = 1'b1;
    pc_sel   = sel;
    imm      = im;
    rs1_val  = rs1;
    step();
    inst_ack = 1'b0;
    pc_sel   = 2'd0;
    imm      = 16'd0;
    rs1_val  = 32'd0;
    exp_pc   = model_next(exp_pc, sel, im, rs1);
    check_val("ack_clears_valid", {31'd0, inst_valid}, 32'd0);
  endtask

  initial begin
    logic [1:0]  rsel;
    logic [31:0] rrs1;
    n_checks    = 0;
    n_errors    = 0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    inst_ack    = 1'b0;
    pc_sel      = 2'd0;
    imm         = 16'd0;
    rs1_val     = 32'd0;
    exp_pc      = START_PC;

    // reset state
    reset = 1'b1;
    step();
    step();
    check_val("rst_req", {31'd0, imem_req}, 32'd0);
    check_val("rst_valid", {31'd0, inst_valid}, 32'd0);
    check_val("rst_inst", inst, 32'd0);
    check_val("rst_pc", pc, START_PC);
    check_val("rst_fault", {31'd0, fetch_fault}, 32'd0);
    reset = 1'b0;
    #1;
    check_val("rst_release_req", {31'd0, imem_req}, 32'd1);

    // zero-wait sequential fetches: 0x0, 0x4, 0x8, then 0xC
    fetch_one(0, 0, 0, 32'hA000_0001, 2'd0, 16'd0, 32'd0);
    fetch_one(0, 0, 0, 32'hA000_0002, 2'd0, 16'd0, 32'd0);
    fetch_one(0, 0, 0, 32'hA000_0003, 2'd0, 16'd0, 32'd0);
    check_val("seq_addr_0c", imem_addr, 32'h0000_000C);
    fetch_one(0, 0, 0, 32'hA000_0004, 2'd0, 16'd0, 32'd0);
    check_val("seq_addr_10", imem_addr, 32'h0000_0010);

    // backward branch from 0x10 by imm -2 words
    fetch_one(0, 0, 0, 32'hB000_0001, 2'd1, 16'hFFFE, 32'd0);
    check_val("branch_addr", imem_addr, 32'h0000_000C);

    // jump to rs1 + 3 words
    fetch_one(0, 0, 0, 32'hB000_0002, 2'd2, 16'h0003, 32'h0000_0100);
    check_val("jump_addr", imem_addr, 32'h0000_010C);

    // slow memory: ready 5 cycles late, data 3 cycles late
    fetch_one(5, 3, 2, 32'hC0DE_0001, 2'd0, 16'd0, 32'd0);
    check_val("slow_addr", imem_addr, 32'h0000_0110);

    // reset while waiting for read data
    check_val("r5_req", {31'd0, imem_req}, 32'd1);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    check_val("r5_in_wait", {31'd0, imem_req}, 32'd0);
    reset = 1'b1;
    step();
    check_val("r5_pc", pc, START_PC);
    check_val("r5_valid", {31'd0, inst_valid}, 32'd0);
    check_val("r5_req_low", {31'd0, imem_req}, 32'd0);
    reset = 1'b0;
    #1;
    check_val("r5_restart_req", {31'd0, imem_req}, 32'd1);
    check_val("r5_restart_addr", imem_addr, START_PC);
    exp_pc = START_PC;

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
`ifdef INST_FETCH_ALIGN_CHK_EN
      rsel = 2'($urandom_range(0, 2));
      rrs1 = $urandom & 32'hFFFF_FFFC;
`else
      rsel = 2'($urandom_range(0, 3));
      rrs1 = $urandom;
`endif
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom,
                rsel, 16'($urandom), rrs1);
    end

`ifdef INST_FETCH_ALIGN_CHK_EN
    // misaligned jump target faults; fault is sticky and blocks requests
    fetch_one(0, 0, 0, 32'hFA17_0001, 2'd0, 16'd0, 32'd0);
    begin
      logic [31:0] fault_pc;
      fault_pc = exp_pc;
      check_val("pre_fault_req", {31'd0, imem_req}, 32'd1);
      imem_ready = 1'b1;
      step();
      imem_ready  = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h1234_5678;
      step();
      imem_rvalid = 1'b0;
      inst_ack = 1'b1;
      pc_sel   = 2'd2;
      imm      = 16'd0;
      rs1_val  = 32'h0000_0102;
      step();
      inst_ack = 1'b0;
      for (int i = 0; i < 6; i++) begin
        check_val("fault_sticky", {31'd0, fetch_fault}, 32'd1);
        check_val("fault_no_req", {31'd0, imem_req}, 32'd0);
        check_val("fault_pc", pc, fault_pc);
        check_val("fault_valid", {31'd0, inst_valid}, 32'd0);
        imem_ready  = 1'b1;
        imem_rvalid = 1'b1;
        inst_ack    = 1'b1;
        step();
      end
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      inst_ack    = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
